// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Parses host frames from the UART receiver byte stream and writes the
// pixels into the image buffer. Frame = SYNC_BYTE, IMG_PIXELS pixel bytes,
// then one checksum byte (8-bit wrapping sum of the pixels).
//
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   rx_dv, rx_byte      : one-cycle byte strobe and byte from the UART receiver
//   wr_en/addr/data     : image buffer write port, one cycle per pixel
//   busy                : frame in progress (payload or checksum phase)
//   frame_done          : one-cycle pulse, frame complete and checksum good
//   frame_err           : one-cycle pulse, frame aborted
//   err_code            : last error cause (0 none, 1 checksum, 2 timeout)
module uart_frame_loader #(
  parameter int          IMG_PIXELS   = 784,
  parameter int          ADDR_W       = $clog2(IMG_PIXELS),
  parameter int          TIMEOUT_CLKS = 10_000_000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHKSUM} state_t;

  localparam int TW = $clog2(TIMEOUT_CLKS);
  // The error is registered on the cycle the timer would step onto
  // TIMEOUT_CLKS-1, so frame_err lands TIMEOUT_CLKS cycles after the last byte.
  localparam logic [TW-1:0]     T_TERM = TW'(TIMEOUT_CLKS - 2);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        sum;
  logic [TW-1:0]     timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sum        <= '0;
      timer      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv && rx_byte == SYNC_BYTE) begin
            state <= PAYLOAD;
            cnt   <= '0;
            sum   <= '0;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        PAYLOAD, CHKSUM: begin
          // A byte arriving on the terminal timer cycle takes priority.
          if (rx_dv) begin
            timer <= '0;
            if (state == PAYLOAD) begin
              wr_en   <= 1'b1;
              wr_addr <= cnt;
              wr_data <= rx_byte;
              sum     <= sum + rx_byte;
              if (cnt == LAST) state <= CHKSUM;
              else             cnt   <= cnt + 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (rx_byte == sum) begin
                frame_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                err_code  <= 2'd1;
              end
            end
          end else if (timer == T_TERM) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            err_code  <= 2'd2;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader with IMG_PIXELS=4, TIMEOUT_CLKS=100.
// A frame-level model (payload queue, cycle stamps) predicts the outputs,
// a negedge process compares every cycle, and literal checks pin the model.
module tb_uart_frame_loader;
  localparam int N  = 4;
  localparam int TC = 100;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          wr_en, busy, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [1:0]    err_code;

  uart_frame_loader #(.IMG_PIXELS(N), .TIMEOUT_CLKS(TC), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // ---------------- frame-level model ----------------
  int       cyc = 0;
  bit       mv = 0;
  bit       in_frame = 0;
  int       last_cyc = 0;
  byte unsigned pl[$];
  bit       e_wr_en, e_busy, e_done, e_err;
  int       e_addr, e_data, e_code;

  always @(posedge clk) begin
    int s;
    cyc++;
    e_wr_en = 0; e_done = 0; e_err = 0;
    if (reset) begin
      mv = 1; in_frame = 0; e_busy = 0; e_code = 0; e_addr = 0; e_data = 0;
    end else if (in_frame) begin
      if (rx_dv) begin
        last_cyc = cyc;
        if (pl.size() < N) begin
          e_wr_en = 1; e_addr = pl.size(); e_data = rx_byte;
          pl.push_back(rx_byte);
        end else begin
          s = 0;
          foreach (pl[i]) s += pl[i];
          if ((s % 256) == rx_byte) e_done = 1;
          else begin e_err = 1; e_code = 1; end
          in_frame = 0; e_busy = 0;
        end
      end else if (cyc - last_cyc == TC - 1) begin
        e_err = 1; e_code = 2; in_frame = 0; e_busy = 0;
      end
    end else if (rx_dv && rx_byte == 8'hA5) begin
      in_frame = 1; pl.delete(); last_cyc = cyc; e_busy = 1;
    end
  end

  // ---------------- compare + monitor ----------------
  int n_done = 0, n_err = 0, t_err = 0;
  int wlog[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mv) begin
      chk("wr_en", int'(wr_en), int'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_addr", int'(wr_addr), e_addr);
        chk("wr_data", int'(wr_data), e_data);
      end
      chk("busy", int'(busy), int'(e_busy));
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("frame_err", int'(frame_err), int'(e_err));
      chk("err_code", int'(err_code), e_code);
    end
    if (wr_en === 1'b1) wlog.push_back({24'd0, 6'(wr_addr), wr_data} );
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) begin n_err++; t_err = cyc; end
  end

  // ---------------- stimulus ----------------
  // Entry/exit invariant: 1 time unit after a posedge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    idle(gap);
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, ck);
    send(8'hA5, 1); send(p0, 1); send(p1, 0); send(p2, 2); send(p3, 1); send(ck, 1);
  endtask

  int d0, e0, t0;

  initial begin
    idle(3);
    // reset state
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst err_code", int'(err_code), 0);
    reset = 1'b0;
    idle(2);

    // 1: leading junk byte, good frame
    d0 = n_done; wlog.delete();
    send(8'h11, 1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    idle(2);
    chk("s1 done count", n_done - d0, 1);
    chk("s1 writes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("s1 w0", wlog[0], 16'h0001);
      chk("s1 w3", wlog[3], 16'h0304);
    end
    chk("s1 err_code", int'(err_code), 0);

    // 2: checksum wraps
    d0 = n_done;
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
    idle(2);
    chk("s2 done count", n_done - d0, 1);

    // 3: sync value as data, back-to-back bytes
    d0 = n_done; wlog.delete();
    send(8'hA5, 0); send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'hA5, 2);
    chk("s3 done count", n_done - d0, 1);
    chk("s3 writes", wlog.size(), 4);
    if (wlog.size() == 4) chk("s3 w0", wlog[0], 16'h00A5);

    // 4: bad checksum, then a good frame keeps err_code
    d0 = n_done; e0 = n_err;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
    idle(1);
    chk("s4 err count", n_err - e0, 1);
    chk("s4 done count", n_done - d0, 0);
    chk("s4 err_code", int'(err_code), 1);
    // sync right in the cycle after frame_done is tested in this pair
    send(8'hA5, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h0A, 0);
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h04, 2);
    chk("s4 done after", n_done - d0, 2);
    chk("s4 code held", int'(err_code), 1);

    // 5: timeout after 0x02
    e0 = n_err;
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 0);
    t0 = cyc;
    idle(TC + 5);
    chk("s5 err count", n_err - e0, 1);
    chk("s5 latency", t_err - t0 + 1, 100);
    chk("s5 err_code", int'(err_code), 2);
    chk("s5 busy", int'(busy), 0);
    // next frame restarts at address 0; bytes land exactly at terminal count
    wlog.delete(); d0 = n_done; e0 = n_err;
    send(8'hA5, TC - 2); send(8'h07, TC - 2); send(8'h00, TC - 2); send(8'h00, 0); send(8'h00, 0);
    send(8'h07, 2);
    chk("s5 tc no err", n_err - e0, 0);
    chk("s5 tc done", n_done - d0, 1);
    if (wlog.size() > 0) chk("s5 addr0", wlog[0], 16'h0007);
    else chk("s5 writes", wlog.size(), 4);

    // 6: reset mid-frame
    d0 = n_done; e0 = n_err;
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 0);
    reset = 1'b1;
    idle(1);
    chk("s6 wr_en", int'(wr_en), 0);
    chk("s6 busy", int'(busy), 0);
    chk("s6 err_code", int'(err_code), 0);
    reset = 1'b0;
    idle(1);
    chk("s6 no pulses", (n_done - d0) + (n_err - e0), 0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    idle(2);
    chk("s6 done", n_done - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
